// File: rtl/cmp_pkg.sv
// Shared types and constants for the digit-serial magnitude comparator family.
package cmp_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} cmp_state_t;
   localparam int unsigned DIGIT_W = 2;
endpackage

// File: rtl/cmp2_slice.sv
// Two-bit magnitude compare slice with EQ/GT cascade; purely combinational.
module cmp2_slice
   import cmp_pkg::*;
(
   input  logic [DIGIT_W-1:0] da,
   input  logic [DIGIT_W-1:0] db,
   input  logic               eq_in,
   input  logic               gt_in,
   output logic               eq_o,
   output logic               gt_o
);
   assign eq_o = eq_in & (da == db);
   assign gt_o = gt_in | (eq_in & (da > db));
endmodule

// File: rtl/serial_mag_comparator.sv
// Digit-serial unsigned comparator: walks the operands MSB-first, one 2-bit digit per cycle,
// feeding the EQ/GT cascade back through registers so a single slice does the whole compare.
module serial_mag_comparator
   import cmp_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter bit          EARLY_EXIT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             eq_out,
   output logic             gt_out,
   output logic             lt_out
);
   localparam int unsigned CNT_W = $clog2(WIDTH / 2 + 1);

   if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_width_check
      $error("serial_mag_comparator: WIDTH must be even and >= 2");
   end

   cmp_state_t       state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             eq_acc_q, eq_acc_d;
   logic             gt_acc_q, gt_acc_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             eq_q, eq_d;
   logic             gt_q, gt_d;
   logic             lt_q, lt_d;
   logic             slice_eq, slice_gt;

   cmp2_slice u_slice (
      .da    (a_sh_q[WIDTH-1 -: DIGIT_W]),
      .db    (b_sh_q[WIDTH-1 -: DIGIT_W]),
      .eq_in (eq_acc_q),
      .gt_in (gt_acc_q),
      .eq_o  (slice_eq),
      .gt_o  (slice_gt)
   );

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      cnt_d    = cnt_q;
      eq_acc_d = eq_acc_q;
      gt_acc_d = gt_acc_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      eq_d     = eq_q;
      gt_d     = gt_q;
      lt_d     = lt_q;
      unique case (state_q)
         // DONE accepts a new request exactly like IDLE, giving back-to-back operation.
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               state_d  = RUN;
               busy_d   = 1'b1;
               a_sh_d   = a;
               b_sh_d   = b;
               eq_acc_d = 1'b1;
               gt_acc_d = 1'b0;
               cnt_d    = CNT_W'(WIDTH / 2);
            end
         end
         RUN: begin
            eq_acc_d = slice_eq;
            gt_acc_d = slice_gt;
            a_sh_d   = a_sh_q << DIGIT_W;
            b_sh_d   = b_sh_q << DIGIT_W;
            cnt_d    = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1) || (EARLY_EXIT && !slice_eq)) begin
               state_d = DONE;
               done_d  = 1'b1;
               eq_d    = slice_eq;
               gt_d    = slice_gt;
               lt_d    = ~slice_eq & ~slice_gt;
            end else begin
               busy_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         cnt_q    <= '0;
         eq_acc_q <= 1'b0;
         gt_acc_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         eq_q     <= 1'b0;
         gt_q     <= 1'b0;
         lt_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         cnt_q    <= cnt_d;
         eq_acc_q <= eq_acc_d;
         gt_acc_q <= gt_acc_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         eq_q     <= eq_d;
         gt_q     <= gt_d;
         lt_q     <= lt_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign eq_out = eq_q;
   assign gt_out = gt_q;
   assign lt_out = lt_q;
endmodule

// File: tb/tb_serial_mag_comparator.sv
// Bench for serial_mag_comparator: two WIDTH=8 instances (early exit on/off) and one WIDTH=2.
module tb_serial_mag_comparator;
   import cmp_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start_e, start_n, start_2;
   logic [7:0] a, b;
   logic [1:0] a2, b2;
   logic       busy_e, done_e, eq_e, gt_e, lt_e;
   logic       busy_n, done_n, eq_n, gt_n, lt_n;
   logic       busy_2, done_2, eq_2, gt_2, lt_2;

   int unsigned cyc = 0;
   int          errors = 0;
   int          checks = 0;
   logic        prev_e = 1'b0, prev_n = 1'b0, prev_2 = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_dut_e (
      .clk(clk), .rst(rst), .start(start_e), .a(a), .b(b), .busy(busy_e), .done(done_e),
      .eq_out(eq_e), .gt_out(gt_e), .lt_out(lt_e));
   serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_dut_n (
      .clk(clk), .rst(rst), .start(start_n), .a(a), .b(b), .busy(busy_n), .done(done_n),
      .eq_out(eq_n), .gt_out(gt_n), .lt_out(lt_n));
   serial_mag_comparator #(.WIDTH(2), .EARLY_EXIT(1'b1)) u_dut_2 (
      .clk(clk), .rst(rst), .start(start_2), .a(a2), .b(b2), .busy(busy_2), .done(done_2),
      .eq_out(eq_2), .gt_out(gt_2), .lt_out(lt_2));

   typedef struct {
      logic        eq, gt, lt;
      int unsigned start_edge;
      int unsigned lat;
   } exp_t;

   typedef struct {
      logic [7:0]  a, b;
      logic        eq, gt, lt;
      int unsigned lat_e;
   } vec_t;

   exp_t q_e[$], q_n[$], q_2[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Independent golden compare; latency is the 1-based index of the first differing digit.
   function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input int w,
                                  input bit early, input int unsigned st);
      exp_t r;
      r.eq = (x == y);
      r.gt = (x > y);
      r.lt = (x < y);
      r.lat = w / 2;
      r.start_edge = st;
      if (early) begin
         for (int i = 0; i < w / 2; i++) begin
            if (x[w-1-2*i -: 2] != y[w-1-2*i -: 2]) begin
               r.lat = i + 1;
               break;
            end
         end
      end
      return r;
   endfunction

   task automatic score(input string name, input exp_t x, input logic eq, input logic gt,
                        input logic lt, input logic prev);
      check({name, " result eq/gt/lt"}, {eq, gt, lt}, {x.eq, x.gt, x.lt});
      check({name, " latency"}, cyc - x.start_edge, x.lat);
      check({name, " done pulse width"}, prev, 0);
   endtask

   always @(negedge clk) begin
      exp_t x;
      if (!rst && done_e) begin
         if (q_e.size() == 0) begin
            errors++;
            $display("FAIL early unexpected done: got 1 expected 0 (cycle %0d)", cyc);
         end else begin
            x = q_e.pop_front();
            score("early", x, eq_e, gt_e, lt_e, prev_e);
         end
      end
      prev_e = !rst && done_e;
   end

   always @(negedge clk) begin
      exp_t x;
      if (!rst && done_n) begin
         if (q_n.size() == 0) begin
            errors++;
            $display("FAIL full unexpected done: got 1 expected 0 (cycle %0d)", cyc);
         end else begin
            x = q_n.pop_front();
            score("full", x, eq_n, gt_n, lt_n, prev_n);
         end
      end
      prev_n = !rst && done_n;
   end

   always @(negedge clk) begin
      exp_t x;
      if (!rst && done_2) begin
         if (q_2.size() == 0) begin
            errors++;
            $display("FAIL w2 unexpected done: got 1 expected 0 (cycle %0d)", cyc);
         end else begin
            x = q_2.pop_front();
            score("w2", x, eq_2, gt_2, lt_2, prev_2);
         end
      end
      prev_2 = !rst && done_2;
   end

   // Called at posedge+1; the next edge accepts the request.
   task automatic go8(input logic [7:0] xa, input logic [7:0] xb, input exp_t ee, input exp_t en);
      a = xa;
      b = xb;
      start_e = 1'b1;
      start_n = 1'b1;
      ee.start_edge = cyc + 1;
      en.start_edge = cyc + 1;
      q_e.push_back(ee);
      q_n.push_back(en);
      @(posedge clk); #1;
      start_e = 1'b0;
      start_n = 1'b0;
      check("busy after start", {busy_e, busy_n}, 2'b11);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((q_e.size() + q_n.size() + q_2.size()) != 0 && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, " pending results drained"}, q_e.size() + q_n.size() + q_2.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs[8];
      exp_t ee, en;
      logic [7:0] ra, rb;

      vecs[0] = '{a: 8'hA5, b: 8'hA5, eq: 1, gt: 0, lt: 0, lat_e: 4};
      vecs[1] = '{a: 8'h80, b: 8'h7F, eq: 0, gt: 1, lt: 0, lat_e: 1};
      vecs[2] = '{a: 8'h12, b: 8'h13, eq: 0, gt: 0, lt: 1, lat_e: 4};
      vecs[3] = '{a: 8'h40, b: 8'h50, eq: 0, gt: 0, lt: 1, lat_e: 2};
      vecs[4] = '{a: 8'hC8, b: 8'hC4, eq: 0, gt: 1, lt: 0, lat_e: 3};
      vecs[5] = '{a: 8'h00, b: 8'h00, eq: 1, gt: 0, lt: 0, lat_e: 4};
      vecs[6] = '{a: 8'hFF, b: 8'h00, eq: 0, gt: 1, lt: 0, lat_e: 1};
      vecs[7] = '{a: 8'h00, b: 8'hFF, eq: 0, gt: 0, lt: 1, lat_e: 1};

      rst = 1'b1;
      start_e = 1'b0;
      start_n = 1'b0;
      start_2 = 1'b0;
      a = '0;
      b = '0;
      a2 = '0;
      b2 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset outputs early", {busy_e, done_e, eq_e, gt_e, lt_e}, 0);
      check("reset outputs full", {busy_n, done_n, eq_n, gt_n, lt_n}, 0);
      check("reset outputs w2", {busy_2, done_2, eq_2, gt_2, lt_2}, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         ee = '{eq: vecs[i].eq, gt: vecs[i].gt, lt: vecs[i].lt, start_edge: 0,
                lat: vecs[i].lat_e};
         en = ee;
         en.lat = 4;
         go8(vecs[i].a, vecs[i].b, ee, en);
         wait_idle("table");
      end

      for (int i = 0; i < 6; i++) begin
         ra = 8'($urandom);
         rb = (i % 3 == 0) ? ra : 8'($urandom);
         go8(ra, rb, model(ra, rb, 8, 1'b1, 0), model(ra, rb, 8, 1'b0, 0));
         wait_idle("random");
      end

      // Start held through RUN with wandering operands, then a back-to-back request in DONE.
      a = 8'h5A;
      b = 8'h5A;
      start_n = 1'b1;
      q_n.push_back(model(8'h5A, 8'h5A, 8, 1'b0, cyc + 1));
      @(posedge clk); #1;
      check("held start busy", busy_n, 1);
      for (int i = 0; i < 4; i++) begin
         a = 8'($urandom);
         b = ~a;
         @(posedge clk); #1;
      end
      check("held start done cycle", {busy_n, done_n}, 2'b01);
      a = 8'hFF;
      b = 8'h00;
      q_n.push_back(model(8'hFF, 8'h00, 8, 1'b0, cyc + 1));
      @(posedge clk); #1;
      start_n = 1'b0;
      check("back-to-back busy", {busy_n, done_n}, 2'b10);
      check("result held across new start", {eq_n, gt_n, lt_n}, 3'b100);
      wait_idle("back-to-back");

      // Asynchronous reset in the second RUN cycle.
      a = 8'h12;
      b = 8'h13;
      start_e = 1'b1;
      start_n = 1'b1;
      @(posedge clk); #1;
      start_e = 1'b0;
      start_n = 1'b0;
      @(posedge clk); #2;
      check("busy before mid-run reset", {busy_e, busy_n}, 2'b11);
      rst = 1'b1;
      #1;
      check("mid-run reset early", {busy_e, done_e, eq_e, gt_e, lt_e}, 0);
      check("mid-run reset full", {busy_n, done_n, eq_n, gt_n, lt_n}, 0);
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("no done after reset", {busy_e, done_e, busy_n, done_n}, 0);
      ee = model(8'h3C, 8'h3C, 8, 1'b1, 0);
      en = model(8'h3C, 8'h3C, 8, 1'b0, 0);
      go8(8'h3C, 8'h3C, ee, en);
      wait_idle("after reset");

      for (int i = 0; i < 16; i++) begin
         a2 = 2'(i >> 2);
         b2 = 2'(i);
         start_2 = 1'b1;
         q_2.push_back(model({6'b0, a2}, {6'b0, b2}, 2, 1'b1, cyc + 1));
         @(posedge clk); #1;
         start_2 = 1'b0;
         check("w2 busy after start", busy_2, 1);
         wait_idle("w2 sweep");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
